mpt_tlb: RTL and testbench

- Parametrised, fully associative, SDID-tagged cache of completed MPT walk results.
- Sits between the requester's physical-address check port and the MPT walker. Replaces the single fixed-size TLB entry type with N entries of mixed page size (4 KiB / 2 MiB / 1 GiB).
- Lookups that hit resolve permission in one cycle. Misses report hit=0 so the requester starts a walk; the walker returns its result through the fill port.
- Supports global flush and per-SDID flush.

---
 rtl/mpt_tlb_pkg.sv | 55 +++++
 rtl/mpt_tlb_if.sv | 35 +++
 rtl/mpt_tlb_victim_sel.sv | 64 ++++++
 rtl/mpt_tlb.sv | 155 +++++++++++++++
 tb/tb_mpt_tlb.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mpt_tlb_pkg.sv
// Shared types and helpers for the MPT walk-result TLB.
package mpt_tlb_pkg;

    typedef enum logic [1:0] {
        PG_4K   = 2'b00,
        PG_2M   = 2'b01,
        PG_1G   = 2'b10,
        PG_RSVD = 2'b11
    } mpt_page_size_e;

    typedef enum logic [1:0] {
        ACCESS_NONE  = 2'b00,
        ACCESS_READ  = 2'b01,
        ACCESS_WRITE = 2'b10,
        ACCESS_EXEC  = 2'b11
    } mpt_access_e;

    typedef enum logic [1:0] {
        DISALLOWED = 2'b00,
        ALLOW_RX   = 2'b01,
        ALLOW_RW   = 2'b10,
        ALLOW_RWX  = 2'b11
    } TLB_permissions_e;

    // Width of the largest in-page offset (1 GiB pages).
    localparam int unsigned MPT_OFFSET_W = 30;

    // Permission check of one stored entry against the requested access.
    function automatic logic mpt_perm_allows(TLB_permissions_e perm, mpt_access_e access);
        logic allow;
        case (access)
            ACCESS_READ:  allow = (perm != DISALLOWED);
            ACCESS_WRITE: allow = (perm == ALLOW_RW) || (perm == ALLOW_RWX);
            ACCESS_EXEC:  allow = (perm == ALLOW_RX) || (perm == ALLOW_RWX);
            ACCESS_NONE:  allow = 1'b0;
            default:      allow = 1'b0;
        endcase
        return allow;
    endfunction

    // In-page offset bits for a page size; the page base is everything above them.
    // The reserved size maps to the widest offset, but such fills never reach the array.
    function automatic logic [MPT_OFFSET_W-1:0] mpt_page_mask(mpt_page_size_e size);
        logic [MPT_OFFSET_W-1:0] offs;
        case (size)
            PG_4K:   offs = 30'h0000_0FFF;
            PG_2M:   offs = 30'h001F_FFFF;
            PG_1G:   offs = 30'h3FFF_FFFF;
            PG_RSVD: offs = 30'h3FFF_FFFF;
            default: offs = 30'h3FFF_FFFF;
        endcase
        return offs;
    endfunction

endpackage

// File: rtl/mpt_tlb_if.sv
// Requester / walker / flush signals of the MPT TLB grouped as one bus.
interface mpt_tlb_if #(
    parameter int unsigned PLEN     = 56,
    parameter int unsigned SDID_LEN = 6
);
    logic                lookup_valid_i;
    logic [PLEN-1:0]     lookup_paddr_i;
    logic [SDID_LEN-1:0] lookup_sdid_i;
    logic [1:0]          lookup_access_i;
    logic                lookup_valid_o;
    logic                lookup_hit_o;
    logic                lookup_allow_o;
    logic                fill_valid_i;
    logic [PLEN-1:0]     fill_paddr_i;
    logic [SDID_LEN-1:0] fill_sdid_i;
    logic [1:0]          fill_size_i;
    logic [1:0]          fill_perm_i;
    logic                flush_i;
    logic                flush_sdid_en_i;
    logic [SDID_LEN-1:0] flush_sdid_i;

    modport master (
        output lookup_valid_i, lookup_paddr_i, lookup_sdid_i, lookup_access_i,
        output fill_valid_i, fill_paddr_i, fill_sdid_i, fill_size_i, fill_perm_i,
        output flush_i, flush_sdid_en_i, flush_sdid_i,
        input  lookup_valid_o, lookup_hit_o, lookup_allow_o
    );

    modport slave (
        input  lookup_valid_i, lookup_paddr_i, lookup_sdid_i, lookup_access_i,
        input  fill_valid_i, fill_paddr_i, fill_sdid_i, fill_size_i, fill_perm_i,
        input  flush_i, flush_sdid_en_i, flush_sdid_i,
        output lookup_valid_o, lookup_hit_o, lookup_allow_o
    );
endinterface

// File: rtl/mpt_tlb_victim_sel.sv
// Fill-slot chooser: duplicate tag first, then lowest free slot, then round-robin victim.
module mpt_tlb_victim_sel #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_ENTRIES-1:0] valid_i,
    input  logic [NUM_ENTRIES-1:0] dup_i,
    input  logic                   advance_i,
    input  logic                   reset_ptr_i,
    output logic [IDX_W-1:0]       sel_idx_o,
    output logic                   evict_o
);
    localparam logic [IDX_W-1:0] ONE_IDX = IDX_W'(1'b1);

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] free_idx_s;
    logic [IDX_W-1:0] dup_idx_s;
    logic             free_found_s;
    logic             dup_found_s;

    // Lowest-index free slot and lowest-index duplicate tag (scan high to low, last write wins).
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = '0;
        dup_found_s  = 1'b0;
        dup_idx_s    = '0;
        for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
            free_idx_s   = (!valid_i[i]) ? IDX_W'(i) : free_idx_s;
            free_found_s = free_found_s | ~valid_i[i];
            dup_idx_s    = dup_i[i] ? IDX_W'(i) : dup_idx_s;
            dup_found_s  = dup_found_s | dup_i[i];
        end
    end

    // Slot choice in priority order; only the last resort evicts a live entry.
    always_comb begin
        sel_idx_o = ptr_r;
        evict_o   = 1'b0;
        if (dup_found_s) begin
            sel_idx_o = dup_idx_s;
        end else if (free_found_s) begin
            sel_idx_o = free_idx_s;
        end else begin
            sel_idx_o = ptr_r;
            evict_o   = 1'b1;
        end
    end

    // Round-robin victim pointer; wraps naturally because the entry count is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_r <= '0;
        end else if (reset_ptr_i) begin
            ptr_r <= '0;
        end else if (advance_i) begin
            ptr_r <= ptr_r + ONE_IDX;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/mpt_tlb.sv
// Fully associative, SDID-tagged cache of MPT walk results with mixed page sizes.
module mpt_tlb
    import mpt_tlb_pkg::*;
#(
    parameter int unsigned PLEN        = 56,
    parameter int unsigned SDID_LEN    = 6,
    parameter int unsigned NUM_ENTRIES = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    mpt_tlb_if.slave                      bus,
    output logic [$clog2(NUM_ENTRIES):0]  occupancy_o
);
    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

    typedef struct packed {
        logic                valid;
        mpt_page_size_e      size;
        TLB_permissions_e    perm;
        logic [PLEN-1:0]     paddr;
        logic [SDID_LEN-1:0] sdid;
    } mpt_tlb_entry_t;

    mpt_tlb_entry_t         entries_r [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid_vec_s;
    logic [NUM_ENTRIES-1:0] valid_next_s;
    logic [NUM_ENTRIES-1:0] match_vec_s;
    logic [NUM_ENTRIES-1:0] dup_vec_s;
    logic [NUM_ENTRIES-1:0] flush_match_s;
    logic [IDX_W-1:0]       lookup_idx_s;
    logic                   lookup_hit_s;
    logic                   lookup_allow_s;
    logic [PLEN-1:0]        fill_mask_s;
    logic [PLEN-1:0]        fill_base_s;
    mpt_page_size_e         fill_size_s;
    logic                   fill_accept_s;
    logic [IDX_W-1:0]       fill_idx_s;
    logic                   evict_s;
    logic [IDX_W:0]         count_s;
    logic                   resp_valid_r;
    logic                   resp_hit_r;
    logic                   resp_allow_r;
    logic [IDX_W:0]         occupancy_r;

    assign fill_size_s   = mpt_page_size_e'(bus.fill_size_i);
    assign fill_mask_s   = ~{{(PLEN-MPT_OFFSET_W){1'b0}}, mpt_page_mask(fill_size_s)};
    assign fill_base_s   = bus.fill_paddr_i & fill_mask_s;
    // A flush in the same cycle may make the walk result stale, so it wins.
    assign fill_accept_s = bus.fill_valid_i && (fill_size_s != PG_RSVD) && !bus.flush_i;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
        logic [PLEN-1:0] mask_s;
        assign mask_s = ~{{(PLEN-MPT_OFFSET_W){1'b0}}, mpt_page_mask(entries_r[g].size)};
        assign valid_vec_s[g]   = entries_r[g].valid;
        assign match_vec_s[g]   = entries_r[g].valid
                               && (entries_r[g].sdid == bus.lookup_sdid_i)
                               && ((bus.lookup_paddr_i & mask_s) == entries_r[g].paddr);
        assign dup_vec_s[g]     = entries_r[g].valid
                               && (entries_r[g].sdid == bus.fill_sdid_i)
                               && (entries_r[g].size == fill_size_s)
                               && (entries_r[g].paddr == fill_base_s);
        assign flush_match_s[g] = (entries_r[g].sdid == bus.flush_sdid_i);
    end

    // Lowest matching index wins when page sizes overlap.
    always_comb begin
        lookup_hit_s = 1'b0;
        lookup_idx_s = '0;
        for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
            lookup_idx_s = match_vec_s[i] ? IDX_W'(i) : lookup_idx_s;
            lookup_hit_s = lookup_hit_s | match_vec_s[i];
        end
    end

    assign lookup_allow_s = mpt_perm_allows(entries_r[lookup_idx_s].perm,
                                            mpt_access_e'(bus.lookup_access_i));

    mpt_tlb_victim_sel #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_victim_sel (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_vec_s),
        .dup_i       (dup_vec_s),
        .advance_i   (fill_accept_s && evict_s),
        .reset_ptr_i (bus.flush_i && !bus.flush_sdid_en_i),
        .sel_idx_o   (fill_idx_s),
        .evict_o     (evict_s)
    );

    // Next valid vector: flush (global or per-SDID) beats fill.
    always_comb begin
        valid_next_s = valid_vec_s;
        if (bus.flush_i) begin
            if (bus.flush_sdid_en_i) begin
                valid_next_s = valid_vec_s & ~flush_match_s;
            end else begin
                valid_next_s = '0;
            end
        end else if (fill_accept_s) begin
            valid_next_s[fill_idx_s] = 1'b1;
        end else begin
            valid_next_s = valid_vec_s;
        end
    end

    // Popcount of the post-update valid vector.
    always_comb begin
        count_s = '0;
        for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            count_s = count_s + {{IDX_W{1'b0}}, valid_next_s[i]};
        end
    end

    // Entry array: valid bits track flush/fill, payload written only on an accepted fill.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                entries_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                entries_r[i].valid <= valid_next_s[i];
            end
            if (fill_accept_s) begin
                entries_r[fill_idx_s].size  <= fill_size_s;
                entries_r[fill_idx_s].perm  <= TLB_permissions_e'(bus.fill_perm_i);
                entries_r[fill_idx_s].paddr <= fill_base_s;
                entries_r[fill_idx_s].sdid  <= bus.fill_sdid_i;
            end
        end
    end

    // Registered lookup response (pre-update contents) and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_r <= 1'b0;
            resp_hit_r   <= 1'b0;
            resp_allow_r <= 1'b0;
            occupancy_r  <= '0;
        end else begin
            resp_valid_r <= bus.lookup_valid_i;
            resp_hit_r   <= bus.lookup_valid_i && lookup_hit_s;
            resp_allow_r <= bus.lookup_valid_i && lookup_hit_s && lookup_allow_s;
            occupancy_r  <= count_s;
        end
    end

    assign bus.lookup_valid_o = resp_valid_r;
    assign bus.lookup_hit_o   = resp_hit_r;
    assign bus.lookup_allow_o = resp_allow_r;
    assign occupancy_o        = occupancy_r;

endmodule

// File: tb/tb_mpt_tlb.sv
// Directed scoreboard bench for mpt_tlb.
module tb_mpt_tlb;
    import mpt_tlb_pkg::*;

    localparam int unsigned PLEN        = 56;
    localparam int unsigned SDID_LEN    = 6;
    localparam int unsigned NUM_ENTRIES = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] occupancy;

    mpt_tlb_if #(.PLEN(PLEN), .SDID_LEN(SDID_LEN)) bus ();

    mpt_tlb #(
        .PLEN        (PLEN),
        .SDID_LEN    (SDID_LEN),
        .NUM_ENTRIES (NUM_ENTRIES)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .occupancy_o (occupancy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_q [$];
    string      name_q [$];
    logic [1:0] mon_exp;
    string      mon_name;

    // Monitor: pops the expected {hit,allow} whenever a response is presented.
    always @(negedge clk) begin
        if (bus.lookup_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: hit=%0b allow=%0b, required no response",
                         bus.lookup_hit_o, bus.lookup_allow_o);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                if ({bus.lookup_hit_o, bus.lookup_allow_o} !== mon_exp) begin
                    errors++;
                    $display("FAIL %s: hit=%0b allow=%0b, required hit=%0b allow=%0b",
                             mon_name, bus.lookup_hit_o, bus.lookup_allow_o, mon_exp[1], mon_exp[0]);
                end
            end
        end else begin
            checks++;
            if (bus.lookup_hit_o || bus.lookup_allow_o) begin
                errors++;
                $display("FAIL idle_resp: hit=%0b allow=%0b without valid, required 0 0",
                         bus.lookup_hit_o, bus.lookup_allow_o);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input logic [7:0] act, input logic [7:0] exp, input string nm);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic check_occ(input logic [3:0] exp, input string nm);
        check_val({4'h0, occupancy}, {4'h0, exp}, nm);
    endtask

    task automatic idle_inputs();
        bus.lookup_valid_i  = 1'b0;
        bus.lookup_paddr_i  = 56'h0;
        bus.lookup_sdid_i   = 6'd0;
        bus.lookup_access_i = 2'b00;
        bus.fill_valid_i    = 1'b0;
        bus.fill_paddr_i    = 56'h0;
        bus.fill_sdid_i     = 6'd0;
        bus.fill_size_i     = 2'b00;
        bus.fill_perm_i     = 2'b00;
        bus.flush_i         = 1'b0;
        bus.flush_sdid_en_i = 1'b0;
        bus.flush_sdid_i    = 6'd0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic set_lookup(input logic [55:0] pa, input logic [5:0] sd, input logic [1:0] acc,
                              input logic eh, input logic ea, input string nm);
        bus.lookup_valid_i  = 1'b1;
        bus.lookup_paddr_i  = pa;
        bus.lookup_sdid_i   = sd;
        bus.lookup_access_i = acc;
        exp_q.push_back({eh, ea});
        name_q.push_back(nm);
    endtask

    task automatic set_fill(input logic [55:0] pa, input logic [5:0] sd,
                            input logic [1:0] sz, input logic [1:0] pm);
        bus.fill_valid_i = 1'b1;
        bus.fill_paddr_i = pa;
        bus.fill_sdid_i  = sd;
        bus.fill_size_i  = sz;
        bus.fill_perm_i  = pm;
    endtask

    task automatic lookup(input logic [55:0] pa, input logic [5:0] sd, input logic [1:0] acc,
                          input logic eh, input logic ea, input string nm);
        set_lookup(pa, sd, acc, eh, ea, nm);
        cycle();
    endtask

    task automatic fill(input logic [55:0] pa, input logic [5:0] sd,
                        input logic [1:0] sz, input logic [1:0] pm);
        set_fill(pa, sd, sz, pm);
        cycle();
    endtask

    task automatic flush(input logic en, input logic [5:0] sd);
        bus.flush_i         = 1'b1;
        bus.flush_sdid_en_i = en;
        bus.flush_sdid_i    = sd;
        cycle();
    endtask

    function automatic logic [55:0] pg(input logic [55:0] base, input int k);
        return base + (56'(k) << 12);
    endfunction

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check_occ(4'd0, "reset_occupancy");
        check_val({7'd0, bus.lookup_valid_o}, 8'd0, "reset_valid");
        check_val({6'd0, bus.lookup_hit_o, bus.lookup_allow_o}, 8'd0, "reset_hit_allow");

        // Empty TLB misses
        lookup(56'h8000_1000, 6'd3, ACCESS_READ, 1'b0, 1'b0, "empty_miss");
        check_occ(4'd0, "empty_occupancy");

        // 4K entry, base masked at fill
        fill(56'h8000_1234, 6'd3, PG_4K, ALLOW_RX);
        check_occ(4'd1, "fill4k_occupancy");
        lookup(56'h8000_1FF8, 6'd3, ACCESS_READ,  1'b1, 1'b1, "4k_read");
        lookup(56'h8000_1FF8, 6'd3, ACCESS_WRITE, 1'b1, 1'b0, "4k_write");
        lookup(56'h8000_1FF8, 6'd3, ACCESS_EXEC,  1'b1, 1'b1, "4k_exec");
        lookup(56'h8000_1FF8, 6'd4, ACCESS_READ,  1'b0, 1'b0, "4k_other_sdid");
        lookup(56'h8000_2000, 6'd3, ACCESS_READ,  1'b0, 1'b0, "4k_next_page");

        // 1G entry
        fill(56'h4000_0000, 6'd1, PG_1G, ALLOW_RW);
        check_occ(4'd2, "fill1g_occupancy");
        lookup(56'h7FFF_FFF0, 6'd1, ACCESS_WRITE, 1'b1, 1'b1, "1g_write");
        lookup(56'h8000_0000, 6'd1, ACCESS_WRITE, 1'b0, 1'b0, "1g_outside");
        lookup(56'h4000_0000, 6'd1, ACCESS_NONE,  1'b1, 1'b0, "1g_access_none");
        lookup(56'h4000_0000, 6'd1, ACCESS_EXEC,  1'b1, 1'b0, "1g_exec");

        // Reserved size fill dropped
        fill(56'h9000_0000, 6'd1, PG_RSVD, ALLOW_RWX);
        check_occ(4'd2, "rsvd_occupancy");
        lookup(56'h9000_0000, 6'd1, ACCESS_READ, 1'b0, 1'b0, "rsvd_miss");

        // Capacity and round-robin eviction
        flush(1'b0, 6'd0);
        check_occ(4'd0, "flush_before_evict");
        for (int k = 0; k < 8; k++) begin
            fill(pg(56'h2000_0000, k), 6'd2, PG_4K, ALLOW_RWX);
        end
        check_occ(4'd8, "full_occupancy");
        fill(pg(56'h2000_0000, 8), 6'd2, PG_4K, ALLOW_RWX);
        check_occ(4'd8, "saturated_occupancy");
        lookup(pg(56'h2000_0000, 0), 6'd2, ACCESS_READ, 1'b0, 1'b0, "evicted_page0");
        lookup(pg(56'h2000_0000, 8), 6'd2, ACCESS_READ, 1'b1, 1'b1, "page8_hit");
        lookup(pg(56'h2000_0000, 1), 6'd2, ACCESS_READ, 1'b1, 1'b1, "page1_before");
        // Identical tag overwritten in place, pointer stays at 1
        fill(pg(56'h2000_0000, 3) + 56'h10, 6'd2, PG_4K, DISALLOWED);
        check_occ(4'd8, "dup_occupancy");
        lookup(pg(56'h2000_0000, 3), 6'd2, ACCESS_READ, 1'b1, 1'b0, "dup_new_perm");
        fill(pg(56'h2000_0000, 9), 6'd2, PG_4K, ALLOW_RWX);
        lookup(pg(56'h2000_0000, 1), 6'd2, ACCESS_READ, 1'b0, 1'b0, "evicted_page1");
        lookup(pg(56'h2000_0000, 2), 6'd2, ACCESS_READ, 1'b1, 1'b1, "page2_kept");
        lookup(pg(56'h2000_0000, 9), 6'd2, ACCESS_READ, 1'b1, 1'b1, "page9_hit");

        // Global flush resets pointer; per-SDID flush
        flush(1'b0, 6'd0);
        check_occ(4'd0, "global_flush_occupancy");
        fill(56'h3000_0000, 6'd1, PG_4K, ALLOW_RWX);
        fill(56'h3000_1000, 6'd2, PG_4K, ALLOW_RWX);
        fill(56'h3000_2000, 6'd1, PG_4K, ALLOW_RWX);
        check_occ(4'd3, "three_fill_occupancy");
        flush(1'b1, 6'd1);
        check_occ(4'd1, "sdid_flush_occupancy");
        lookup(56'h3000_0000, 6'd1, ACCESS_READ, 1'b0, 1'b0, "sdid1_a_flushed");
        lookup(56'h3000_1000, 6'd2, ACCESS_READ, 1'b1, 1'b1, "sdid2_kept");
        lookup(56'h3000_2000, 6'd1, ACCESS_READ, 1'b0, 1'b0, "sdid1_c_flushed");
        for (int k = 0; k < 7; k++) begin
            fill(pg(56'h3100_0000, k), 6'd6, PG_4K, ALLOW_RWX);
        end
        check_occ(4'd8, "refill_occupancy");
        fill(pg(56'h3100_0000, 7), 6'd6, PG_4K, ALLOW_RWX);
        lookup(pg(56'h3100_0000, 0), 6'd6, ACCESS_READ, 1'b0, 1'b0, "ptr0_victim");
        lookup(pg(56'h3100_0000, 1), 6'd6, ACCESS_READ, 1'b1, 1'b1, "ptr0_d1_kept");
        lookup(56'h3000_1000, 6'd2, ACCESS_READ, 1'b1, 1'b1, "ptr0_b_kept");

        // Overlapping sizes: lowest index wins
        flush(1'b0, 6'd0);
        fill(56'h0020_0000, 6'd7, PG_2M, ALLOW_RX);
        fill(56'h0020_1000, 6'd7, PG_4K, ALLOW_RW);
        check_occ(4'd2, "overlap_occupancy");
        lookup(56'h0020_1008, 6'd7, ACCESS_WRITE, 1'b1, 1'b0, "overlap_write");
        lookup(56'h0020_1008, 6'd7, ACCESS_EXEC,  1'b1, 1'b1, "overlap_exec");

        // flush + fill + lookup in one cycle
        flush(1'b0, 6'd0);
        fill(56'h5000_0000, 6'd4, PG_4K, ALLOW_RX);
        check_occ(4'd1, "pre_combo_occupancy");
        bus.flush_i         = 1'b1;
        bus.flush_sdid_en_i = 1'b0;
        set_fill(56'h5000_1000, 6'd4, PG_4K, ALLOW_RX);
        set_lookup(56'h5000_0000, 6'd4, ACCESS_READ, 1'b1, 1'b1, "combo_preflush_hit");
        cycle();
        check_occ(4'd0, "combo_occupancy");
        lookup(56'h5000_0000, 6'd4, ACCESS_READ, 1'b0, 1'b0, "combo_flushed");
        lookup(56'h5000_1000, 6'd4, ACCESS_READ, 1'b0, 1'b0, "combo_fill_dropped");

        // fill + lookup in one cycle: no bypass
        set_fill(56'h6000_0000, 6'd5, PG_4K, ALLOW_RW);
        set_lookup(56'h6000_0000, 6'd5, ACCESS_READ, 1'b0, 1'b0, "no_bypass");
        cycle();
        check_occ(4'd1, "bypass_occupancy");
        lookup(56'h6000_0000, 6'd5, ACCESS_READ, 1'b1, 1'b1, "after_fill_hit");

        // Reset during a lookup
        rst = 1'b1;
        bus.lookup_valid_i  = 1'b1;
        bus.lookup_paddr_i  = 56'h6000_0000;
        bus.lookup_sdid_i   = 6'd5;
        bus.lookup_access_i = ACCESS_READ;
        cycle();
        rst = 1'b0;
        check_val({7'd0, bus.lookup_valid_o}, 8'd0, "midreset_valid");
        check_occ(4'd0, "midreset_occupancy");
        lookup(56'h6000_0000, 6'd5, ACCESS_READ, 1'b0, 1'b0, "midreset_miss");

        repeat (3) @(posedge clk);
        #1;
        check_val(8'(exp_q.size()), 8'd0, "scoreboard_drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
